// File: rtl/position_bank_mm.sv
`default_nettype none
// ============================================================================
// Module   : position_bank_mm
// Purpose  : Double-buffered bank of NUM_CH object-position registers behind
//            an Avalon-MM slave. Software writes shadow registers at any
//            time; a commit request copies every shadow register into the
//            active bank at the next frame_sync rising edge, so the renderer
//            always sees a consistent per-frame snapshot.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_clk         in   system clock (rising edge)
//   reset_reset     in   asynchronous active-high reset
//   avs_address     in   word address
//                          0..NUM_CH-1 shadow regs (R/W, byte-enabled)
//                          NUM_CH      CTRL   (W)  [0]=commit [1]=clear
//                          NUM_CH+1    STATUS (R)  [0]=pending [1]=copy
//                                                  [31:16]=frame_count
//   avs_write       in   write strobe
//   avs_writedata   in   write data
//   avs_byteenable  in   byte lanes for writes
//   avs_read        in   read strobe
//   avs_readdata    out  registered read data, latency 1, held between reads
//   frame_sync      in   vertical-sync level
//   positions_flat  out  active bank, channel k at [k*DATA_W +: DATA_W]
//   commit_done     out  one-cycle pulse when the active bank updates
//   frame_count     out  number of completed commits (wraps at 16 bits)
// ----------------------------------------------------------------------------
// Build option:
//   POSITION_BANK_READBACK_EN  when defined, shadow addresses read back the
//                              shadow contents; otherwise they read as 0 and
//                              no readback multiplexer is built.
// Assumes DATA_W >= 32 so the STATUS word fits.
// ============================================================================
module position_bank_mm #(
    parameter int NUM_CH = 37,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset,
    input  logic [ADDR_W-1:0]        avs_address,
    input  logic                     avs_write,
    input  logic [DATA_W-1:0]        avs_writedata,
    input  logic [DATA_W/8-1:0]      avs_byteenable,
    input  logic                     avs_read,
    output logic [DATA_W-1:0]        avs_readdata,
    input  logic                     frame_sync,
    output logic [NUM_CH*DATA_W-1:0] positions_flat,
    output logic                     commit_done,
    output logic [15:0]              frame_count
);

    localparam int                NUM_BYTES     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] c_ADDR_CTRL   = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] c_ADDR_STATUS = ADDR_W'(NUM_CH + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              fs_q;
    logic [DATA_W-1:0] shadow_q [NUM_CH];
    logic [DATA_W-1:0] shadow_d [NUM_CH];
    logic [DATA_W-1:0] active_q [NUM_CH];
    logic [DATA_W-1:0] active_d [NUM_CH];
    logic              commit_done_q, commit_done_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;

    logic              w_edge;
    logic              w_ctrl_wr;
    logic              w_commit_req;
    logic              w_clear;
    logic [31:0]       w_status;
    logic [DATA_W-1:0] w_rd_mux;

    assign w_edge       = frame_sync & ~fs_q;
    assign w_ctrl_wr    = avs_write && (avs_address == c_ADDR_CTRL);
    assign w_commit_req = w_ctrl_wr & avs_writedata[0];
    assign w_clear      = w_ctrl_wr & avs_writedata[1];
    assign w_status     = {frame_count_q, 14'd0,
                           (state_q == ST_COPY), (state_q == ST_PENDING)};

    // Read multiplexer: sees pre-write state, so a same-cycle read and write
    // to one shadow address returns the old value.
    always_comb begin
        w_rd_mux = '0;
        if (avs_address == c_ADDR_STATUS) begin
            w_rd_mux = DATA_W'(w_status);
        end
`ifdef POSITION_BANK_READBACK_EN
        for (int k = 0; k < NUM_CH; k++) begin
            if (avs_address == ADDR_W'(k)) begin
                w_rd_mux = shadow_q[k];
            end
        end
`endif
    end

    // Next-state, shadow/active bank and bus-side register updates.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        commit_done_d = 1'b0;
        frame_count_d = frame_count_q;
        readdata_d    = readdata_q;

        if (avs_read) begin
            readdata_d = w_rd_mux;
        end

        if (w_clear) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_d[k] = '0;
            end
        end

        for (int k = 0; k < NUM_CH; k++) begin
            if (avs_write && (avs_address == ADDR_W'(k))) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (avs_byteenable[b]) begin
                        shadow_d[k][b*8 +: 8] = avs_writedata[b*8 +: 8];
                    end
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (w_commit_req) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_edge) begin
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                // Copy from the registered shadow bank so writes or a clear
                // landing in this same cycle are deferred to the next commit.
                active_d      = shadow_q;
                commit_done_d = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
                state_d       = w_commit_req ? ST_PENDING : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q       <= ST_IDLE;
            fs_q          <= 1'b0;
            shadow_q      <= '{default: '0};
            active_q      <= '{default: '0};
            commit_done_q <= 1'b0;
            frame_count_q <= 16'd0;
            readdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            fs_q          <= frame_sync;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            commit_done_q <= commit_done_d;
            frame_count_q <= frame_count_d;
            readdata_q    <= readdata_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign positions_flat[g*DATA_W +: DATA_W] = active_q[g];
    end

    assign avs_readdata = readdata_q;
    assign commit_done  = commit_done_q;
    assign frame_count  = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_position_bank_mm.sv
`default_nettype none
// ============================================================================
// Module   : tb_position_bank_mm
// Purpose  : Self-checking bench for position_bank_mm. Directed scenarios
//            followed by randomized bus/frame_sync traffic, all compared each
//            cycle against a behavioural model of the register bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_position_bank_mm;

    localparam int NUM_CH = 37;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int A_CTRL = NUM_CH;
    localparam int A_STAT = NUM_CH + 1;

    logic                     clk_clk;
    logic                     reset_reset;
    logic [ADDR_W-1:0]        avs_address;
    logic                     avs_write;
    logic [DATA_W-1:0]        avs_writedata;
    logic [DATA_W/8-1:0]      avs_byteenable;
    logic                     avs_read;
    logic [DATA_W-1:0]        avs_readdata;
    logic                     frame_sync;
    logic [NUM_CH*DATA_W-1:0] positions_flat;
    logic                     commit_done;
    logic [15:0]              frame_count;

    position_bank_mm #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .avs_address    (avs_address),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_byteenable (avs_byteenable),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .frame_sync     (frame_sync),
        .positions_flat (positions_flat),
        .commit_done    (commit_done),
        .frame_count    (frame_count)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    int n_total = 0;
    int n_bad   = 0;

    // ---------------- behavioural model ----------------
    logic [31:0] m_shadow [NUM_CH];
    logic [31:0] m_active [NUM_CH];
    bit          m_pending;   // commit requested, waiting for a frame edge
    bit          m_copying;   // copy takes effect at the end of this cycle
    bit          m_fs;        // frame_sync as seen last cycle
    bit          m_done;
    logic [15:0] m_count;
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
        m_pending = 0;
        m_copying = 0;
        m_fs      = 0;
        m_done    = 0;
        m_count   = '0;
        m_rdata   = '0;
    endtask

    function automatic logic [31:0] m_read(input int a);
        logic [31:0] r;
        r = '0;
        if (a == A_STAT) r = {m_count, 14'd0, m_copying, m_pending};
`ifdef POSITION_BANK_READBACK_EN
        else if (a < NUM_CH) r = m_shadow[a];
`endif
        return r;
    endfunction

    // Applies one clock edge's worth of bus/frame rules to the model.
    task automatic model_step();
        bit fedge, req, clr;
        int a;
        a     = int'(avs_address);
        fedge = frame_sync && !m_fs;
        req   = avs_write && (a == A_CTRL) && avs_writedata[0];
        clr   = avs_write && (a == A_CTRL) && avs_writedata[1];
        if (avs_read) m_rdata = m_read(a);
        m_done = m_copying;
        if (m_copying) begin
            for (int k = 0; k < NUM_CH; k++) m_active[k] = m_shadow[k];
            m_count   = m_count + 16'd1;
            m_copying = 0;
            m_pending = req;
        end else if (m_pending) begin
            if (fedge) begin
                m_pending = 0;
                m_copying = 1;
            end
        end else if (req) begin
            m_pending = 1;
        end
        if (clr) begin
            for (int k = 0; k < NUM_CH; k++) m_shadow[k] = '0;
        end
        if (avs_write && a < NUM_CH) begin
            for (int b = 0; b < 4; b++)
                if (avs_byteenable[b]) m_shadow[a][b*8 +: 8] = avs_writedata[b*8 +: 8];
        end
        m_fs = frame_sync;
    endtask

    task automatic compare_all();
        chk("commit_done", 32'(commit_done), 32'(m_done));
        chk("frame_count", 32'(frame_count), 32'(m_count));
        chk("readdata", avs_readdata, m_rdata);
        for (int k = 0; k < NUM_CH; k++)
            chk($sformatf("pos%0d", k), positions_flat[k*32 +: 32], m_active[k]);
    endtask

    task automatic tick();
        @(posedge clk_clk);
        if (reset_reset) model_reset();
        else             model_step();
        #1;
        compare_all();
        avs_write = 1'b0;
        avs_read  = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        avs_address    = 6'(a);
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        tick();
    endtask

    task automatic rd(input int a);
        avs_address = 6'(a);
        avs_read    = 1'b1;
        tick();
    endtask

    task automatic fs_pulse();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
    endtask

    logic [31:0] exp_be;
    int          r;

    initial begin
        reset_reset    = 1'b1;
        avs_address    = '0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        avs_byteenable = '0;
        avs_read       = 1'b0;
        frame_sync     = 1'b0;
        model_reset();
        repeat (2) tick();
        reset_reset = 1'b0;

        // Reset state
        rd(A_STAT);
        chk("status_after_reset", avs_readdata, 32'h0);

        // Basic commit; commit_done two cycles after the edge
        wr(0, 32'h00640032, 4'hF);
        wr(36, 32'h01E00280, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        tick();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("done_not_yet", 32'(commit_done), 32'h0);
        tick();
        chk("done_edge_plus2", 32'(commit_done), 32'h1);
        chk("ch0_active", positions_flat[31:0], 32'h00640032);
        chk("ch36_active", positions_flat[36*32 +: 32], 32'h01E00280);
        chk("fcount_1", 32'(frame_count), 32'h1);
        tick();

        // Write without commit: frame edge changes nothing
        wr(5, 32'h0000AAAA, 4'hF);
        fs_pulse();
        repeat (2) tick();
        chk("ch5_unchanged", positions_flat[5*32 +: 32], 32'h0);

        // Write landing in the COPY cycle is deferred
        wr(A_CTRL, 32'h1, 4'hF);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        wr(3, 32'h00001234, 4'hF);
        tick();
        chk("ch3_old_active", positions_flat[3*32 +: 32], 32'h0);
        rd(3);

        // Byte-enabled write and readback
        wr(1, 32'hFFFFFFFF, 4'b0010);
        rd(1);
`ifdef POSITION_BANK_READBACK_EN
        exp_be = 32'h0000FF00;
`else
        exp_be = 32'h0;
`endif
        chk("be_readback", avs_readdata, exp_be);

        // Same-cycle read and write to one address returns the old value
        avs_read = 1'b1;
        wr(1, 32'h11111111, 4'hF);

        // Clear and commit in one CTRL write
        wr(A_CTRL, 32'h3, 4'hF);
        fs_pulse();
        tick();

        // frame_count wrap: preload the counter next to its limit
        dut.frame_count_q = 16'hFFFF;
        m_count           = 16'hFFFF;
        tick();
        wr(A_CTRL, 32'h1, 4'hF);
        wr(7, 32'hCAFEF00D, 4'hF);
        fs_pulse();
        chk("fcount_wrap", 32'(frame_count), 32'h0);
        tick();

        // Reset asserted mid-COPY acts without a clock edge
        wr(A_CTRL, 32'h1, 4'hF);
        rd(A_STAT);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        #2;
        reset_reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("rst_fcount", 32'(frame_count), 32'h0);
        tick();
        reset_reset = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            r              = int'($urandom_range(0, 99));
            avs_address    = 6'($urandom_range(0, 63));
            avs_read       = ($urandom_range(0, 2) == 0);
            if (r < 40) begin
                avs_address    = 6'($urandom_range(0, 40));
                avs_writedata  = $urandom;
                avs_byteenable = 4'($urandom);
                avs_write      = 1'b1;
            end else if (r < 52) begin
                avs_address    = 6'(A_CTRL);
                avs_writedata  = {30'($urandom), ($urandom_range(0, 9) == 0), 1'b1};
                avs_byteenable = 4'hF;
                avs_write      = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) frame_sync = ~frame_sync;
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/position_bank_mm.md
# position_bank_mm

Parametrised, double-buffered bank of object-position registers behind an Avalon-MM slave.

- Nios software writes per-object positions into shadow registers at any time.
- On a software commit request, the block copies all shadow registers to the active registers at the next frame-sync rising edge.
- The sprite renderer therefore always sees a consistent snapshot of the frame.
- It replaces the fixed set of per-object 32-bit PIO exports in the system with one N-channel block.

## Interface
Parameters:
- NUM_CH, 37, number of position channels.
- DATA_W, 32, bits per channel; must be a multiple of 8.
- ADDR_W, 6, word-address width; 2^ADDR_W ≥ NUM_CH+2.

Ports:
- clk_clk  in  1  system clock; all logic is on its rising edge.
- reset_reset  in  1  asynchronous, active-high reset.
- avs_address  in  ADDR_W  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  DATA_W  write data.
- avs_byteenable  in  DATA_W/8  byte lanes for writes.
- avs_read  in  1  read strobe.
- avs_readdata  out  DATA_W  registered read data (read latency 1).
- frame_sync  in  1  vertical-sync level from the VGA controller.
- positions_flat  out  NUM_CH*DATA_W  active registers; channel k is at bits [k*DATA_W +: DATA_W].
- commit_done  out  1  one-cycle pulse when the active registers update.
- frame_count  out  16  number of completed commits.

## Operation
Address map:
- Addresses 0..NUM_CH-1: shadow channel registers, read/write, byte-enabled.
- Address NUM_CH: CTRL, write-only.
  - writedata[0]=1 requests a commit.
  - writedata[1]=1 clears all shadow registers to 0.
  - If both bits are set, the clear applies first, then the commit request.
- Address NUM_CH+1: STATUS, read-only.
  - bit0 = pending.
  - bit1 = state is COPY.
  - bits[31:16] = frame_count.
- Writes to any other address are ignored. Reads from any other address return 0.

Frame-sync edge detection:
- frame_sync is registered once into fs_q.
- edge = frame_sync & ~fs_q.

State machine:
- IDLE: a commit request moves to PENDING. An edge has no effect.
- PENDING: an edge moves to COPY. Further commit requests are ignored.
- COPY: lasts exactly one cycle.
  - On the exiting clock edge, active <= shadow.
  - commit_done <= 1 for one cycle.
  - frame_count <= frame_count+1, wrapping 0xFFFF→0x0000.
  - Next state is IDLE.

Simultaneous events:
- Shadow write in a PENDING cycle, including the edge cycle: the write is included in the copy.
- Shadow write in the COPY cycle: the copy takes the pre-write shadow value. The write lands in shadow and appears at the next commit.
- Commit request in the COPY cycle: it is registered, and the next state is PENDING instead of IDLE.
- CTRL clear in the COPY cycle: the copy uses pre-clear values.

Other rules:
- Read and write in the same cycle to the same shadow address: readdata returns the old value.
- Active registers are never written by the bus.

## Timing
Reset values (reset asserted, or reset mid-operation, including mid-COPY):
- All shadow and active registers = 0.
- State = IDLE.
- fs_q = 0.
- frame_count = 0.
- commit_done = 0.
- avs_readdata = 0.

Read path:
- avs_read asserted in cycle t gives avs_readdata valid in cycle t+1.
- avs_readdata holds its value until the next read.

Write path:
- A shadow write in cycle t is visible on readback from cycle t+1.

Commit latency:
- An edge detected in cycle t (state PENDING) gives state = COPY in cycle t+1.
- positions_flat, commit_done and frame_count are updated in cycle t+2.
- Minimum latency from CTRL write to a new positions_flat is 3 cycles: write, edge, copy.

The bus never stalls; waitrequest is not used.

## Configuration
- POSITION_BANK_READBACK_EN defined: shadow addresses return the shadow contents on read.
- Not defined: shadow addresses read as 0 and the readback multiplexer is not built. STATUS remains readable in both cases.

## Test plan
- Reset, then read STATUS: readdata=0x00000000 and positions_flat=0.
- Write ch0=0x00640032, ch36=0x01E00280, commit, then pulse frame_sync: commit_done fires 2 cycles after the edge, ch0/ch36 on positions_flat match, and frame_count=1.
- Write ch5=0xAAAA with no commit, then pulse frame_sync: positions_flat is unchanged and commit_done stays 0.
- Commit pending, then write ch3=0x1234 in the COPY cycle: active ch3 keeps its old value and shadow ch3=0x1234.
- Byteenable=4'b0010 write of 0xFFFFFFFF to ch1 (was 0): readback=0x0000FF00 with READBACK_EN defined and 0 without it.
- Preload frame_count=0xFFFF through 65535 commits (or force it), then commit: frame_count=0x0000. Assert reset mid-COPY: all outputs return to 0 asynchronously.
